// File: rtl/data_demux_pkg.sv
// Shared types and helpers for the data_demux receive path.
package data_demux_pkg;

    localparam int MAX_W = 64;
    localparam int LEN_W = 17;

    typedef enum logic [1:0] {
        HUNT,
        LOCKED,
        PACKET
    } state_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } word_class_t;

    // Reverses the low 'width' bits of v; the result is right-aligned.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v,
                                                      input int unsigned     width);
        logic [MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (MAX_W - width);
    endfunction

endpackage

// File: rtl/data_demux_if.sv
// Link-side input stream plus the N routed output streams of the demux.
interface data_demux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_OUTPUTS  = 2
);
    logic [DATA_WIDTH-1:0]                 tdata_in;
    logic                                  tvalid_in;
    logic                                  tready_in;
    logic [N_OUTPUTS-1:0][DATA_WIDTH-1:0]  tdata_out;
    logic [N_OUTPUTS-1:0]                  tvalid_out;
    logic [N_OUTPUTS-1:0]                  tlast_out;
    logic [N_OUTPUTS-1:0]                  tready_out;

    modport master (
        output tdata_in, tvalid_in, tready_out,
        input  tready_in, tdata_out, tvalid_out, tlast_out
    );

    modport slave (
        input  tdata_in, tvalid_in, tready_out,
        output tready_in, tdata_out, tvalid_out, tlast_out
    );
endinterface

// File: rtl/data_demux_axis_out_slice.sv
// Purpose: 1-deep output register slice carrying data, tlast and destination index.
// Latency: 1 cycle from in handshake to out_vld.
// Backpressure: in_rdy = empty or draining this cycle; force_last marks a held word as packet end.
module axis_out_slice #(
    parameter int W      = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_vld,
    input  logic [W-1:0]      in_dat,
    input  logic              in_last,
    input  logic [DEST_W-1:0] in_dest,
    output logic              in_rdy,
    input  logic              force_last,
    output logic              out_vld,
    output logic [W-1:0]      out_dat,
    output logic              out_last,
    output logic [DEST_W-1:0] out_dest,
    input  logic              out_rdy
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
            out_dest <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld  <= 1'b1;
            out_dat  <= in_dat;
            out_last <= in_last;
            out_dest <= in_dest;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end else if (force_last) begin
            // A flushed link still closes the packet the sink has already started.
            out_last <= 1'b1;
        end
    end

endmodule

// File: rtl/data_demux_impl.sv
// Purpose: receive end of the data_mux link; locks on idles, routes masked-header packets to N outputs.
// Latency: a word leaves 1 cycle after the next input beat (one word lookahead for tlast).
// Backpressure: tready_in drops in PACKET while the output slice is full and its sink is stalled.
module data_demux_impl
    import data_demux_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int N_OUTPUTS          = 2,
    parameter bit INPUT_REVERSE_BITS = 1'b1,
    parameter int LOCK_COUNT         = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_demux_if.slave           axis,
    input  logic [3:0]            output_select,
    input  logic [15:0]           max_packet_words,
    input  logic [DATA_WIDTH-1:0] idle_word,
    input  logic [DATA_WIDTH-1:0] idle_word_BX0,
    input  logic [DATA_WIDTH-1:0] header_mask,
    input  logic [DATA_WIDTH-1:0] header,
    input  logic [DATA_WIDTH-1:0] header_BX0,
    input  logic                  clear_counters,
    input  logic                  fc_linkReset,
    output logic                  locked,
    output logic                  bx0_pulse,
    output logic [15:0]           packet_count,
    output logic [15:0]           error_count
);

    localparam int CW = $clog2(LOCK_COUNT + 1);

    logic [DATA_WIDTH-1:0] w_rev, w;
    word_class_t           cls;
    logic                  w_bx0;

    state_t                state, state_nxt;
    logic [CW-1:0]         lock_cnt, cnt_nxt;
    logic [3:0]            sel, sel_nxt;
    logic [LEN_W-1:0]      len, len_nxt;
    logic [DATA_WIDTH-1:0] pend_dat, pend_nxt;
    logic                  drop, tready, acc;
    logic                  push, push_last, pkt_inc, err_inc, bx0_nxt;

    logic                  s_in_rdy, s_vld, s_last, s_rdy;
    logic [DATA_WIDTH-1:0] s_dat;
    logic [3:0]            s_dest;

    assign w_rev = DATA_WIDTH'(bit_reverse(MAX_W'(axis.tdata_in), DATA_WIDTH));
    assign w     = INPUT_REVERSE_BITS ? w_rev : axis.tdata_in;

    // Idle patterns outrank header patterns when both match.
    always_comb begin
        cls   = DATA;
        w_bx0 = 1'b0;
        if (w == idle_word || w == idle_word_BX0) begin
            cls   = IDLE;
            w_bx0 = (w == idle_word_BX0);
        end else if ((w & header_mask) == (header & header_mask) ||
                     (w & header_mask) == (header_BX0 & header_mask)) begin
            cls   = HDR;
            w_bx0 = ((w & header_mask) == (header_BX0 & header_mask));
        end
    end

    assign drop           = ({1'b0, sel} >= 5'(N_OUTPUTS));
    assign tready         = (state == PACKET) ? (drop || s_in_rdy) : 1'b1;
    assign acc            = axis.tvalid_in && tready;
    assign axis.tready_in = tready;
    assign locked         = (state != HUNT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = lock_cnt;
        sel_nxt   = sel;
        len_nxt   = len;
        pend_nxt  = pend_dat;
        push      = 1'b0;
        push_last = 1'b0;
        pkt_inc   = 1'b0;
        err_inc   = 1'b0;
        bx0_nxt   = 1'b0;
        if (fc_linkReset) begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
        end else if (acc) begin
            bx0_nxt = w_bx0 && (state != HUNT);
            case (state)
                HUNT: begin
                    if (cls != IDLE) begin
                        cnt_nxt = '0;
                    end else if (lock_cnt == CW'(LOCK_COUNT - 1)) begin
                        state_nxt = LOCKED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = lock_cnt + CW'(1);
                    end
                end
                LOCKED: begin
                    if (cls == HDR) begin
                        state_nxt = PACKET;
                        sel_nxt   = output_select;
                        len_nxt   = LEN_W'(1);
                        pend_nxt  = w;
                        err_inc   = ({1'b0, output_select} >= 5'(N_OUTPUTS));
                    end else if (cls == DATA) begin
                        state_nxt = HUNT;
                        err_inc   = 1'b1;
                    end
                end
                PACKET: begin
                    push = !drop;
                    if (cls == IDLE) begin
                        push_last = 1'b1;
                        pkt_inc   = !drop;
                        state_nxt = LOCKED;
                    end else begin
                        len_nxt = len + LEN_W'(1);
                        if (max_packet_words != 16'd0 && len_nxt > {1'b0, max_packet_words}) begin
                            // Overlong packet: close what was already forwarded and resync.
                            push_last = 1'b1;
                            err_inc   = 1'b1;
                            state_nxt = HUNT;
                            cnt_nxt   = '0;
                        end else begin
                            pend_nxt = w;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= HUNT;
            lock_cnt  <= '0;
            sel       <= '0;
            len       <= '0;
            pend_dat  <= '0;
            bx0_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_cnt  <= cnt_nxt;
            sel       <= sel_nxt;
            len       <= len_nxt;
            pend_dat  <= pend_nxt;
            bx0_pulse <= bx0_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            packet_count <= '0;
            error_count  <= '0;
        end else if (clear_counters) begin
            packet_count <= '0;
            error_count  <= '0;
        end else begin
            if (pkt_inc)
                packet_count <= packet_count + 16'd1;
            if (err_inc && error_count != 16'hFFFF)
                error_count <= error_count + 16'd1;
        end
    end

    axis_out_slice #(
        .W      (DATA_WIDTH),
        .DEST_W (4)
    ) u_out_slice (
        .clk        (clk),
        .resetn     (resetn),
        .in_vld     (push),
        .in_dat     (pend_dat),
        .in_last    (push_last),
        .in_dest    (sel),
        .in_rdy     (s_in_rdy),
        .force_last (fc_linkReset),
        .out_vld    (s_vld),
        .out_dat    (s_dat),
        .out_last   (s_last),
        .out_dest   (s_dest),
        .out_rdy    (s_rdy)
    );

    // The slice carries its own destination so a trailing word is unaffected by a new header.
    always_comb begin
        axis.tdata_out  = '0;
        axis.tvalid_out = '0;
        axis.tlast_out  = '0;
        s_rdy           = 1'b0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            axis.tdata_out[i] = s_dat;
            if (s_dest == 4'(i)) begin
                axis.tvalid_out[i] = s_vld;
                axis.tlast_out[i]  = s_vld && s_last;
                s_rdy              = axis.tready_out[i];
            end
        end
    end

endmodule

// File: tb/tb_data_demux_impl.sv
// Directed bench for data_demux_impl: lock, routing, backpressure, BX0, length limit, flush, drop, clear.
module tb_data_demux_impl;

    localparam logic [31:0] IDLE_W  = 32'haccccccc;
    localparam logic [31:0] IDLE_BX = 32'ha5555555;
    localparam logic [31:0] HDR_W   = 32'ha0000001;
    localparam logic [31:0] HDR_BX  = 32'h90000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  output_select;
    logic [15:0] max_packet_words;
    logic        clear_counters, fc_linkReset;
    logic        locked, bx0_pulse;
    logic [15:0] packet_count, error_count;

    data_demux_if #(.DATA_WIDTH(32), .N_OUTPUTS(2)) bus ();

    data_demux_impl #(
        .DATA_WIDTH         (32),
        .N_OUTPUTS          (2),
        .INPUT_REVERSE_BITS (1'b1),
        .LOCK_COUNT         (4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .axis             (bus),
        .output_select    (output_select),
        .max_packet_words (max_packet_words),
        .idle_word        (IDLE_W),
        .idle_word_BX0    (IDLE_BX),
        .header_mask      (32'hf0000000),
        .header           (HDR_W),
        .header_BX0       (HDR_BX),
        .clear_counters   (clear_counters),
        .fc_linkReset     (fc_linkReset),
        .locked           (locked),
        .bx0_pulse        (bx0_pulse),
        .packet_count     (packet_count),
        .error_count      (error_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rx_dat[$];
    logic        rx_last[$];
    int          rx_port[$];
    int          bx0_cnt = 0;
    int          stall_seen = 0;
    int          stall_viol = 0;
    logic        in_pkt = 1'b0;
    logic        toggle_en = 1'b0;
    int          base;
    int          bx_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus.tvalid_out[i] && bus.tready_out[i]) begin
                rx_dat.push_back(bus.tdata_out[i]);
                rx_last.push_back(bus.tlast_out[i]);
                rx_port.push_back(i);
            end
        end
        if (bx0_pulse) bx0_cnt++;
        if (in_pkt && bus.tvalid_out[1] && !bus.tready_out[1]) begin
            stall_seen++;
            if (bus.tready_in) stall_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) bus.tready_out[1] = ~bus.tready_out[1];
    endtask

    task automatic send(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        bus.tdata_in  = rev32(w);
        bus.tvalid_in = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (bus.tready_in) ok = 1'b1;
            else tick();
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        tick();
        bus.tvalid_in = 1'b0;
    endtask

    task automatic relock();
        for (int i = 0; i < 4; i++) send(IDLE_W);
    endtask

    task automatic check_rx(input int idx, input logic [31:0] d, input logic l);
        if (idx < rx_dat.size()) begin
            check($sformatf("rx%0d_dat", idx), rx_dat[idx], d);
            check($sformatf("rx%0d_last", idx), 32'(rx_last[idx]), 32'(l));
            check($sformatf("rx%0d_port", idx), 32'(rx_port[idx]), 32'd1);
        end else begin
            check($sformatf("rx%0d_missing", idx), 32'd0, 32'd1);
        end
    endtask

    task automatic std_packet();
        send(HDR_W);
        send(32'h11111111);
        send(32'h22222222);
        send(32'h33333333);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        bus.tdata_in = '0;
        bus.tvalid_in = 1'b0;
        bus.tready_out = 2'b11;
        output_select = 4'd1;
        max_packet_words = 16'd0;
        clear_counters = 1'b0;
        fc_linkReset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_locked", 32'(locked), 0);
        check("rst_tready_in", 32'(bus.tready_in), 1);
        check("rst_tvalid_out", 32'(bus.tvalid_out), 0);
        check("rst_tlast_out", 32'(bus.tlast_out), 0);
        check("rst_bx0", 32'(bx0_pulse), 0);
        check("rst_pkt_cnt", 32'(packet_count), 0);
        check("rst_err_cnt", 32'(error_count), 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Three idles then data must not lock; four in a row must.
        for (int i = 0; i < 3; i++) send(IDLE_W);
        check("hunt_3idle", 32'(locked), 0);
        send(32'h11111111);
        check("hunt_data_locked", 32'(locked), 0);
        check("hunt_data_err", 32'(error_count), 0);
        for (int i = 0; i < 3; i++) send(IDLE_W);
        check("lock_3of4", 32'(locked), 0);
        send(IDLE_W);
        check("lock_4of4", 32'(locked), 1);

        // Basic packet to output 1.
        base = rx_dat.size();
        std_packet();
        send(IDLE_W);
        repeat (3) tick();
        check("pkt1_words", 32'(rx_dat.size() - base), 4);
        check_rx(base + 0, HDR_W, 1'b0);
        check_rx(base + 1, 32'h11111111, 1'b0);
        check_rx(base + 2, 32'h22222222, 1'b0);
        check_rx(base + 3, 32'h33333333, 1'b1);
        check("pkt1_count", 32'(packet_count), 1);

        // Same packet with the sink toggling ready.
        base = rx_dat.size();
        toggle_en = 1'b1;
        in_pkt = 1'b1;
        std_packet();
        send(IDLE_W);
        in_pkt = 1'b0;
        repeat (8) tick();
        toggle_en = 1'b0;
        bus.tready_out = 2'b11;
        repeat (3) tick();
        check("pkt2_words", 32'(rx_dat.size() - base), 4);
        check_rx(base + 0, HDR_W, 1'b0);
        check_rx(base + 1, 32'h11111111, 1'b0);
        check_rx(base + 2, 32'h22222222, 1'b0);
        check_rx(base + 3, 32'h33333333, 1'b1);
        check("pkt2_count", 32'(packet_count), 2);
        check("stall_seen", 32'(stall_seen > 0), 1);
        check("stall_tready_in", 32'(stall_viol), 0);

        // BX0 idle and BX0 header each pulse once; data in LOCKED is an error.
        bx_base = bx0_cnt;
        base = rx_dat.size();
        send(IDLE_BX);
        check("bx0_idle", 32'(bx0_pulse), 1);
        send(HDR_BX);
        check("bx0_hdr", 32'(bx0_pulse), 1);
        send(IDLE_W);
        check("bx0_low", 32'(bx0_pulse), 0);
        repeat (3) tick();
        check("bx0_count", 32'(bx0_cnt - bx_base), 2);
        check_rx(base, HDR_BX, 1'b1);
        check("pkt3_count", 32'(packet_count), 3);
        send(32'h44444444);
        check("locked_data_err", 32'(error_count), 1);
        check("locked_data_unlock", 32'(locked), 0);

        // Length limit of 3 on a 5-word packet.
        relock();
        max_packet_words = 16'd3;
        base = rx_dat.size();
        std_packet();
        send(32'h44444444);
        repeat (3) tick();
        check("maxlen_words", 32'(rx_dat.size() - base), 3);
        check_rx(base + 0, HDR_W, 1'b0);
        check_rx(base + 1, 32'h11111111, 1'b0);
        check_rx(base + 2, 32'h22222222, 1'b1);
        check("maxlen_err", 32'(error_count), 2);
        check("maxlen_unlock", 32'(locked), 0);
        check("maxlen_pkt_cnt", 32'(packet_count), 3);
        max_packet_words = 16'd0;

        // Out-of-range destination: consumed silently, one error.
        relock();
        output_select = 4'd5;
        base = rx_dat.size();
        send(HDR_W);
        send(32'h66666666);
        send(IDLE_W);
        repeat (3) tick();
        output_select = 4'd1;
        check("drop_words", 32'(rx_dat.size() - base), 0);
        check("drop_err", 32'(error_count), 3);
        check("drop_pkt_cnt", 32'(packet_count), 3);
        check("drop_locked", 32'(locked), 1);

        // Link reset with the output stage stalled.
        base = rx_dat.size();
        bus.tready_out = 2'b00;
        send(HDR_W);
        send(32'h77777777);
        fc_linkReset = 1'b1;
        tick();
        fc_linkReset = 1'b0;
        @(negedge clk);
        check("flush_locked", 32'(locked), 0);
        check("flush_vld", 32'(bus.tvalid_out[1]), 1);
        check("flush_last", 32'(bus.tlast_out[1]), 1);
        check("flush_dat", bus.tdata_out[1], HDR_W);
        tick();
        bus.tready_out = 2'b11;
        repeat (4) tick();
        check("flush_words", 32'(rx_dat.size() - base), 1);
        check_rx(base, HDR_W, 1'b1);
        check("flush_err", 32'(error_count), 3);

        // Clear coinciding with an error increment.
        relock();
        clear_counters = 1'b1;
        send(32'h55555555);
        clear_counters = 1'b0;
        check("clear_err", 32'(error_count), 0);
        check("clear_pkt", 32'(packet_count), 0);
        check("clear_unlock", 32'(locked), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
